// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the memory-access stage.
//   - F3_* : RV32I load/store funct3 encodings used for width/extension decode
//   - mem_state_t : memory-stage FSM states (IDLE, BUSY, DONE)
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the memory stage.
//   Store side: byte enables and lane-replicated write data from funct3 and
//   the (already alignment-forced) low address bits.
//   Load side: lane extraction and sign/zero extension of the read word.
// Ports
//   st_lo      in   2   low address bits of the store
//   st_funct3  in   3   store width
//   st_data    in   32  raw store data (rs2)
//   st_be      out  4   byte enables
//   st_wdata   out  32  replicated store data
//   ld_lo      in   2   latched low address bits of the load
//   ld_funct3  in   3   latched load width/extension
//   rdata      in   32  word returned by memory
//   ld_data    out  32  extended load result
// ---------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_lo,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata[{ld_lo, 3'b000} +: 8];
  assign ld_half = rdata[{ld_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = 4'b0011 << {st_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      F3_W:    ld_data = rdata;
      default: ld_data = rdata;  // reserved 011/110/111 behave as word
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory stage fed directly by EX. Latches one load/store, drives it on a
//   req/ready data-memory port, stalls the core while it is outstanding and
//   returns aligned, extended load data with a one-cycle done pulse.
//   A watchdog ends a BUSY phase after TIMEOUT_CYCLES cycles with bus_err.
// Configuration macro
//   MISALIGN_TRAP_EN : misaligned half/word accesses issue no request and
//                      complete immediately with misaligned=1. When undefined,
//                      misaligned stays 0 and offending low bits are forced 0.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_result, mem_wdata_in   address and store data from EX
//   funct3, MemRead, MemWrite  access width and type (MemWrite wins)
//   dmem_req/we/addr/wdata/be  memory request, held stable while BUSY
//   dmem_ready, dmem_rdata     memory completion and read data
//   load_data                  extended load result, valid with done
//   stall                      hold PC/instruction (combinational)
//   done, bus_err, misaligned  one-cycle completion/status pulses
// ---------------------------------------------------------------------------
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       mem_wdata_in,
  input  logic [2:0]        funct3,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              bus_err,
  output logic              misaligned
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic              req_d, we_d, done_d, err_d, mis_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, load_d;
  logic [3:0]        be_d;

  logic              access, is_byte, is_half, is_word, trap;
  logic [1:0]        eff_lo;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata, ld_data;

  assign access  = MemRead | MemWrite;
  assign is_byte = (funct3 == F3_B) | (funct3 == F3_BU);
  assign is_half = (funct3 == F3_H) | (funct3 == F3_HU);
  assign is_word = ~is_byte & ~is_half;

  // Low address bits that the access actually uses: sub-width alignment bits
  // are dropped, which is what makes non-trapping misaligned accesses legal.
  assign eff_lo = is_byte ? alu_result[1:0] :
                  is_half ? {alu_result[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
  assign trap = (is_half & alu_result[0]) | (is_word & (alu_result[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  lsu_align u_align (
    .st_lo     (eff_lo),
    .st_funct3 (funct3),
    .st_data   (mem_wdata_in),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_lo     (lo_q),
    .ld_funct3 (f3_q),
    .rdata     (dmem_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    req_d   = dmem_req;
    we_d    = dmem_we;
    addr_d  = dmem_addr;
    wdata_d = dmem_wdata;
    be_d    = dmem_be;
    load_d  = load_data;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          cnt_d   = '0;
          f3_d    = funct3;
          lo_d    = eff_lo;
          we_d    = MemWrite;
          addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
          be_d    = MemWrite ? st_be : 4'b1111;
          wdata_d = MemWrite ? st_wdata : 32'h0;
          if (trap) begin
            // Misaligned access completes without touching the bus.
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            load_d  = 32'h0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
          end
        end
      end

      BUSY: begin
        stall = 1'b1;
        if (dmem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          load_d  = dmem_we ? 32'h0 : ld_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          load_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // DONE never looks at MemRead/MemWrite, so the completing instruction
      // cannot re-issue before the pipeline advances.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      dmem_be    <= be_d;
      load_data  <= load_d;
      done       <= done_d;
      bus_err    <= err_d;
      misaligned <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. A behavioural memory responder
//   drives dmem_ready/dmem_rdata; expected lanes, data and extension come
//   from plain arithmetic on size/offset. Honours MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result, mem_wdata_in, dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite, dmem_req, dmem_we, dmem_ready;
  logic [3:0]  dmem_be;
  logic        stall, done, bus_err, misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .mem_wdata_in(mem_wdata_in),
    .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .load_data(load_data), .stall(stall),
    .done(done), .bus_err(bus_err), .misaligned(misaligned)
  );

  typedef struct {
    int          stall_cycles;
    int          busy_cycles;
    logic        got_done;
    logic        stable;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] load;
    logic        err;
    logic        mis;
    logic        stall_in_done;
    logic        done_after;
    logic        err_after;
    logic        req_after;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int offset_of(input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(f3);
    return int'(a % 4) - int'(a % 4) % n;  // aligned down to access size
  endfunction

  function automatic logic exp_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (a % size_of(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(f3);
    return 4'(((1 << n) - 1) << offset_of(f3, a));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n = size_of(f3);
    logic [31:0] v = rd >> (8 * offset_of(f3, a));
    if (n == 4) return rd;
    v = v & ((32'h1 << (8 * n)) - 1);
    if (f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  // ---------------- driver / memory responder ----------------
  // Entered and left at a falling edge. ready_at = BUSY cycle (1-based) on
  // which dmem_ready is given; 0 means never.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd,
                            input int ready_at, output obs_t o);
    o = '{default: 0};
    o.stable     = 1'b1;
    MemWrite     = st;
    MemRead      = st ? 1'($urandom_range(0, 1)) : 1'b1;
    funct3       = f3;
    alu_result   = a;
    mem_wdata_in = d;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (stall) o.stall_cycles++;
      if (dmem_req) begin
        o.busy_cycles++;
        if (o.busy_cycles == 1) begin
          o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {o.addr, o.be, o.wdata, o.we}) begin
          o.stable = 1'b0;
        end
        dmem_ready   = (o.busy_cycles == ready_at);
        dmem_rdata   = dmem_ready ? rd : $urandom();
        // Scramble EX inputs: the latched request must not follow them.
        alu_result   = $urandom();
        mem_wdata_in = $urandom();
        funct3       = 3'($urandom());
      end else begin
        dmem_ready = 1'($urandom());  // must be ignored outside BUSY
        dmem_rdata = $urandom();
      end
      @(posedge clk); @(negedge clk);
      if (done) begin
        o.got_done = 1'b1; o.load = load_data; o.err = bus_err;
        o.mis = misaligned; o.stall_in_done = stall;
        break;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    o.done_after = done; o.err_after = bus_err; o.req_after = dmem_req;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0;
    alu_result = 32'h0; mem_wdata_in = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", dmem_we); end
    checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dmem_addr); end
    checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", dmem_wdata); end
    checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", dmem_be); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load got %h exp 0", load_data); end
    checks++; if ({done, bus_err, misaligned, stall} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {done, bus_err, misaligned, stall});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw();
    obs_t o;
    run_access(1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 2, o);
    checks++; if (o.got_done !== 1'b1) begin errors++; $display("FAIL sw_done got %b exp 1", o.got_done); end
    checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", o.we); end
    checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b exp 1111", o.be); end
    checks++; if (o.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", o.wdata); end
    checks++; if (o.addr !== 32'h1000_0008) begin errors++; $display("FAIL sw_addr got %h exp 10000008", o.addr); end
    checks++; if (o.stall_cycles !== 3) begin errors++; $display("FAIL sw_stall got %0d exp 3", o.stall_cycles); end
    checks++; if (o.stall_in_done !== 1'b0) begin errors++; $display("FAIL sw_stall_done got %b exp 0", o.stall_in_done); end
    checks++; if ({o.done_after, o.req_after} !== 2'b00) begin
      errors++; $display("FAIL sw_pulse got %b exp 00", {o.done_after, o.req_after});
    end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    run_access(1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h8011_2233, 1, o);
    checks++; if (o.load !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_load got %h exp ffffff80", o.load); end
    checks++; if (o.we !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", o.we); end
    run_access(1'b0, 3'b100, 32'h1000_0003, 32'h0, 32'h8011_2233, 3, o);
    checks++; if (o.load !== 32'h0000_0080) begin errors++; $display("FAIL lbu_load got %h exp 00000080", o.load); end
  endtask

  task automatic test_sh();
    obs_t o;
    run_access(1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD, 32'h0, 1, o);
    checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", o.be); end
    checks++; if (o.wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", o.wdata); end
    checks++; if (o.addr !== 32'h1000_0000) begin errors++; $display("FAIL sh_addr got %h exp 10000000", o.addr); end
    checks++; if (o.load !== 32'h0) begin errors++; $display("FAIL sh_load got %h exp 0", o.load); end
  endtask

  task automatic test_misaligned_lw();
    obs_t o;
    run_access(1'b0, 3'b010, 32'h1000_0002, 32'h0, 32'h1234_5678, 1, o);
    checks++; if (o.got_done !== 1'b1) begin errors++; $display("FAIL mis_done got %b exp 1", o.got_done); end
`ifdef MISALIGN_TRAP_EN
    checks++; if (o.busy_cycles !== 0) begin errors++; $display("FAIL mis_req got %0d exp 0", o.busy_cycles); end
    checks++; if (o.mis !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", o.mis); end
    checks++; if (o.load !== 32'h0) begin errors++; $display("FAIL mis_load got %h exp 0", o.load); end
`else
    checks++; if (o.mis !== 1'b0) begin errors++; $display("FAIL mis_flag got %b exp 0", o.mis); end
    checks++; if (o.addr !== 32'h1000_0000) begin errors++; $display("FAIL mis_addr got %h exp 10000000", o.addr); end
    checks++; if (o.load !== 32'h1234_5678) begin errors++; $display("FAIL mis_load got %h exp 12345678", o.load); end
`endif
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 3'b010, 32'h2000_0000, 32'h0, 32'h5555_5555, 0, o);
    checks++; if (o.got_done !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", o.got_done); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", o.err); end
    checks++; if (o.busy_cycles !== 16) begin errors++; $display("FAIL to_busy got %0d exp 16", o.busy_cycles); end
    checks++; if (o.load !== 32'h0) begin errors++; $display("FAIL to_load got %h exp 0", o.load); end
    checks++; if ({o.err_after, o.done_after, o.req_after} !== 3'b000) begin
      errors++; $display("FAIL to_idle got %b exp 000", {o.err_after, o.done_after, o.req_after});
    end
  endtask

  task automatic test_reset_in_busy();
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; alu_result = 32'h3000_0004;
    @(posedge clk); @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_req_busy got %b exp 1", dmem_req); end
    rst_n = 1'b0; MemRead = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({dmem_req, stall, done} !== 3'b000) begin
      errors++; $display("FAIL rb_after_reset got %b exp 000", {dmem_req, stall, done});
    end
    rst_n = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    dmem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({done, dmem_req, bus_err} !== 3'b000) begin
      errors++; $display("FAIL rb_late_ready got %b exp 000", {done, dmem_req, bus_err});
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 60; i++) begin
      logic        st   = 1'($urandom_range(0, 1));
      logic [2:0]  f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom());
      logic [31:0] a    = $urandom();
      logic [31:0] d    = $urandom();
      logic [31:0] rd   = $urandom();
      int          rdy  = $urandom_range(1, 4);
      logic        trap = exp_trap(f3, a);
      run_access(st, f3, a, d, rd, rdy, o);
      checks++; if (o.got_done !== 1'b1) begin errors++; $display("FAIL rnd_done[%0d] got %b exp 1", i, o.got_done); end
      checks++; if (o.mis !== trap) begin errors++; $display("FAIL rnd_mis[%0d] got %b exp %b", i, o.mis, trap); end
      checks++; if (o.done_after !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d] got %b exp 0", i, o.done_after); end
      if (trap) begin
        checks++; if ({o.busy_cycles, o.load} !== {32'd0, 32'h0}) begin
          errors++; $display("FAIL rnd_trap[%0d] got busy %0d load %h exp 0 0", i, o.busy_cycles, o.load);
        end
      end else begin
        checks++; if (o.busy_cycles !== rdy) begin errors++; $display("FAIL rnd_busy[%0d] got %0d exp %0d", i, o.busy_cycles, rdy); end
        checks++; if (o.stall_cycles !== rdy + 1) begin errors++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, o.stall_cycles, rdy + 1); end
        checks++; if (o.addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, o.addr, {a[31:2], 2'b00}); end
        checks++; if (o.we !== st) begin errors++; $display("FAIL rnd_we[%0d] got %b exp %b", i, o.we, st); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL rnd_stable[%0d] got %b exp 1", i, o.stable); end
        checks++; if (o.load !== (st ? 32'h0 : exp_load(f3, a, rd))) begin
          errors++; $display("FAIL rnd_load[%0d] got %h exp %h", i, o.load, st ? 32'h0 : exp_load(f3, a, rd));
        end
        if (st) begin
          checks++; if (o.be !== exp_be(f3, a)) begin errors++; $display("FAIL rnd_be[%0d] got %b exp %b", i, o.be, exp_be(f3, a)); end
          checks++; if (o.wdata !== exp_wdata(f3, d)) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", i, o.wdata, exp_wdata(f3, d)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh();
    test_misaligned_lw();
    test_timeout();
    test_reset_in_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
